// File: rtl/pool2x2_stage.sv
// 2x2 stride-2 signed max-pooling stage: streams vertical pixel pairs from the
// intermediate bank and writes saturated window maxima round-robin to four BRAMs.
module pool2x2_stage #(
  parameter int BD    = 18,
  parameter int IW    = 21,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          ready_in,
  input  logic [IW-1:0] q0_c0,
  input  logic [IW-1:0] q0_c1,
  input  logic [IW-1:0] q0_c2,
  input  logic [IW-1:0] q1_c0,
  input  logic [IW-1:0] q1_c1,
  input  logic [IW-1:0] q1_c2,
  output logic          mpen,
  output logic [AW-1:0] rdaddr,
  output logic          wren,
  output logic [AW-1:0] wraddr,
  output logic [BD-1:0] d_c0,
  output logic [BD-1:0] d_c1,
  output logic [BD-1:0] d_c2,
  output logic [1:0]    bram_num,
  output logic          next_st
);

  localparam int HR = IMG_H / 2;
  localparam int RW = (HR > 1) ? $clog2(HR) : 1;
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(HR - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic signed [IW-1:0] SAT_HI = IW'((1 << (BD - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_LO = IW'(-(1 << (BD - 1)));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic signed [IW-1:0] smax(input logic signed [IW-1:0] a,
                                                input logic signed [IW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [BD-1:0] sat(input logic signed [IW-1:0] m);
    logic [BD-1:0] res;
    if (m > SAT_HI) res = SAT_HI[BD-1:0];
    else if (m < SAT_LO) res = SAT_LO[BD-1:0];
    else res = m[BD-1:0];
    return res;
  endfunction

  logic [1:0]           r_state;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_col;
  logic                 r_drain;
  logic                 r_p_valid;
  logic [RW-1:0]        r_p_row;
  logic [CW-1:0]        r_p_col;
  logic signed [IW-1:0] r_vmax [3];

  logic signed [IW-1:0] w_q0 [3];
  logic signed [IW-1:0] w_q1 [3];
  logic signed [IW-1:0] w_vpair [3];
  logic signed [IW-1:0] w_m [3];
  logic [31:0]          w_row32;
  logic [31:0]          w_col32;
  logic [AW-1:0]        w_wraddr;

  assign w_q0[0] = q0_c0;
  assign w_q0[1] = q0_c1;
  assign w_q0[2] = q0_c2;
  assign w_q1[0] = q1_c0;
  assign w_q1[1] = q1_c1;
  assign w_q1[2] = q1_c2;

  assign w_row32  = 32'(r_p_row);
  assign w_col32  = 32'(r_p_col);
  assign w_wraddr = AW'((w_row32 >> 2) * 32'(IMG_W / 2) + (w_col32 >> 1));

  // Per-channel vertical max of the incoming pair and the full window max.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_vpair[i] = smax(w_q0[i], w_q1[i]);
      w_m[i]     = smax(r_vmax[i], w_vpair[i]);
    end
  end

  // Read sequencer: one address per cycle, then drain and a done pulse.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= 1'b0;
      mpen    <= 1'b0;
      rdaddr  <= '0;
      next_st <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          next_st <= 1'b0;
          if (ready_in) begin
            r_state <= S_READ;
            r_row   <= '0;
            r_col   <= '0;
            mpen    <= 1'b1;
            rdaddr  <= '0;
          end else begin
            mpen <= 1'b0;
          end
        end
        S_READ: begin
          if (r_row == LAST_ROW && r_col == LAST_COL) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
            mpen    <= 1'b0;
          end else begin
            mpen   <= 1'b1;
            rdaddr <= rdaddr + AW'(1'b1);
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + RW'(1'b1);
            end else begin
              r_col <= r_col + CW'(1'b1);
            end
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            next_st <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          next_st <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          mpen    <= 1'b0;
          next_st <= 1'b0;
        end
      endcase
    end
  end

  // Data path: the read tag follows the 1-cycle BRAM latency; odd columns close a window.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_p_valid <= 1'b0;
      r_p_row   <= '0;
      r_p_col   <= '0;
      for (int i = 0; i < 3; i++) r_vmax[i] <= '0;
      wren      <= 1'b0;
      wraddr    <= '0;
      d_c0      <= '0;
      d_c1      <= '0;
      d_c2      <= '0;
      bram_num  <= 2'd0;
    end else begin
      r_p_valid <= mpen;
      r_p_row   <= r_row;
      r_p_col   <= r_col;
      wren      <= 1'b0;
      if (r_p_valid && !r_p_col[0]) begin
        for (int i = 0; i < 3; i++) r_vmax[i] <= w_vpair[i];
      end else if (r_p_valid) begin
        wren     <= 1'b1;
        d_c0     <= sat(w_m[0]);
        d_c1     <= sat(w_m[1]);
        d_c2     <= sat(w_m[2]);
        bram_num <= w_row32[1:0];
        wraddr   <= w_wraddr;
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stage.sv
// Self-checking bench for pool2x2_stage: a 4x4 instance for directed cases and
// a default-size instance for a random run, both checked against a window model.
module tb_pool2x2_stage;
  localparam int BD = 18;
  localparam int IW = 21;
  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst [2];
  logic          rdy [2];
  logic [IW-1:0] q0 [2][3];
  logic [IW-1:0] q1 [2][3];
  logic          mpen [2];
  logic          wren [2];
  logic          nst [2];
  logic [AW-1:0] rdaddr [2];
  logic [AW-1:0] wraddr [2];
  logic [BD-1:0] dd [2][3];
  logic [1:0]    bnum [2];

  pool2x2_stage #(.BD(BD), .IW(IW), .IMG_W(4), .IMG_H(4), .AW(AW)) u_small (
    .clk(clk), .RESET(rst[0]), .ready_in(rdy[0]),
    .q0_c0(q0[0][0]), .q0_c1(q0[0][1]), .q0_c2(q0[0][2]),
    .q1_c0(q1[0][0]), .q1_c1(q1[0][1]), .q1_c2(q1[0][2]),
    .mpen(mpen[0]), .rdaddr(rdaddr[0]), .wren(wren[0]), .wraddr(wraddr[0]),
    .d_c0(dd[0][0]), .d_c1(dd[0][1]), .d_c2(dd[0][2]),
    .bram_num(bnum[0]), .next_st(nst[0]));

  pool2x2_stage #(.BD(BD), .IW(IW), .IMG_W(32), .IMG_H(32), .AW(AW)) u_big (
    .clk(clk), .RESET(rst[1]), .ready_in(rdy[1]),
    .q0_c0(q0[1][0]), .q0_c1(q0[1][1]), .q0_c2(q0[1][2]),
    .q1_c0(q1[1][0]), .q1_c1(q1[1][1]), .q1_c2(q1[1][2]),
    .mpen(mpen[1]), .rdaddr(rdaddr[1]), .wren(wren[1]), .wraddr(wraddr[1]),
    .d_c0(dd[1][0]), .d_c1(dd[1][1]), .d_c2(dd[1][2]),
    .bram_num(bnum[1]), .next_st(nst[1]));

  // Intermediate bank contents (upper/lower row per address) and its 1-cycle read port.
  int up [2][3][512];
  int lo [2][3][512];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < 3; ch++)
        if (mpen[k]) begin
          q0[k][ch] <= IW'(up[k][ch][rdaddr[k][8:0]]);
          q1[k][ch] <= IW'(lo[k][ch][rdaddr[k][8:0]]);
        end
  end

  int e_d [2][3][256];
  int e_b [2][256];
  int e_wa [2][256];
  int e_n [2];
  int e_h [2];
  int g_d0 [2][256];
  int g_b [2][256];
  int g_wa [2][256];
  int max_wa [2];
  int exp_rd [2];
  int t0 [2];
  int done_at [2];
  int first_rd_at [2];
  bit armed [2];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int img_w(input int k);
    return (k == 0) ? 4 : 32;
  endfunction

  function automatic int img_h(input int k);
    return (k == 0) ? 4 : 32;
  endfunction

  function automatic int satm(input int m);
    int hi;
    int lo_v;
    hi   = (1 << (BD - 1)) - 1;
    lo_v = -(1 << (BD - 1));
    if (m > hi) return hi;
    if (m < lo_v) return lo_v;
    return m;
  endfunction

  // Expected write list: every 2x2 window in raster order of the pooled map.
  task automatic build_model(input int k);
    int w;
    int h;
    int a;
    int m;
    w = img_w(k);
    h = img_h(k);
    e_n[k] = 0;
    e_h[k] = 0;
    for (int pr = 0; pr < h / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++) begin
        a = pr * w + 2 * pc;
        for (int ch = 0; ch < 3; ch++) begin
          m = up[k][ch][a];
          if (up[k][ch][a + 1] > m) m = up[k][ch][a + 1];
          if (lo[k][ch][a] > m) m = lo[k][ch][a];
          if (lo[k][ch][a + 1] > m) m = lo[k][ch][a + 1];
          e_d[k][ch][e_n[k]] = satm(m);
        end
        e_b[k][e_n[k]]  = pr % 4;
        e_wa[k][e_n[k]] = (pr / 4) * (w / 2) + pc;
        e_n[k]++;
      end
  endtask

  // Compare process: reads, writes and the done pulse of both instances, every cycle.
  initial begin : cmp
    int i;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst[k]) begin
          if (mpen[k]) begin
            chk("mpen_allowed", int'(armed[k] && exp_rd[k] < img_w(k) * img_h(k) / 2), 1);
            if (exp_rd[k] == 0) first_rd_at[k] = cyc;
            chk("rdaddr", int'(rdaddr[k]), exp_rd[k]);
            exp_rd[k]++;
          end
          if (wren[k]) begin
            if (e_h[k] < e_n[k]) begin
              i = e_h[k];
              for (int ch = 0; ch < 3; ch++)
                chk($sformatf("d_c%0d[%0d]", ch, i), int'($signed(dd[k][ch])), e_d[k][ch][i]);
              chk($sformatf("bram_num[%0d]", i), int'(bnum[k]), e_b[k][i]);
              chk($sformatf("wraddr[%0d]", i), int'(wraddr[k]), e_wa[k][i]);
              g_d0[k][i] = int'($signed(dd[k][0]));
              g_b[k][i]  = int'(bnum[k]);
              g_wa[k][i] = int'(wraddr[k]);
              if (int'(wraddr[k]) > max_wa[k]) max_wa[k] = int'(wraddr[k]);
              e_h[k]++;
            end else begin
              chk("wren_unexpected", 1, 0);
            end
          end
          if (nst[k]) begin
            chk("next_st_armed", int'(armed[k]), 1);
            done_at[k] = cyc;
            armed[k]   = 1'b0;
          end
        end
      end
    end
  end

  task automatic start(input int k);
    build_model(k);
    exp_rd[k] = 0;
    done_at[k] = -1;
    first_rd_at[k] = -1;
    max_wa[k] = 0;
    @(negedge clk);
    rdy[k] = 1'b1;
    t0[k] = cyc + 1;
    armed[k] = 1'b1;
    @(negedge clk);
    rdy[k] = 1'b0;
  endtask

  // Full run; next_st seen at negedge t0+N+2 is the edge T+N+3 of a start sampled at T.
  task automatic run(input int k, input bit poke_busy);
    int n;
    n = img_w(k) * img_h(k) / 2;
    start(k);
    if (poke_busy) begin
      repeat (2) @(negedge clk);
      rdy[k] = 1'b1;
      @(negedge clk);
      rdy[k] = 1'b0;
    end
    repeat (n + 8) @(negedge clk);
    chk("next_st_latency", done_at[k] - t0[k], n + 2);
    chk("first_mpen", first_rd_at[k] - t0[k], 0);
    chk("read_count", exp_rd[k], n);
    chk("write_count", e_h[k], e_n[k]);
  endtask

  task automatic fill_basic();
    for (int a = 0; a < 8; a++)
      for (int ch = 0; ch < 3; ch++) begin
        up[0][ch][a] = 2 * a;
        lo[0][ch][a] = 2 * a + 1;
      end
  endtask

  task automatic check_outputs_zero(input int k, input string tag);
    chk({tag, "_mpen"}, int'(mpen[k]), 0);
    chk({tag, "_rdaddr"}, int'(rdaddr[k]), 0);
    chk({tag, "_wren"}, int'(wren[k]), 0);
    chk({tag, "_wraddr"}, int'(wraddr[k]), 0);
    chk({tag, "_next_st"}, int'(nst[k]), 0);
    chk({tag, "_bram_num"}, int'(bnum[k]), 0);
    for (int ch = 0; ch < 3; ch++) chk({tag, "_d"}, int'(dd[k][ch]), 0);
  endtask

  int lit_d [4] = '{3, 7, 11, 15};
  int lit_b [4] = '{0, 0, 1, 1};
  int lit_wa [4] = '{0, 1, 0, 1};
  int lit_s [4] = '{-3, 131071, -131072, 30};
  int sv_up [8] = '{-5, -3, 500000, 7, -600000, -600000, 10, 20};
  int sv_lo [8] = '{-9, -7, 1, -2, -600000, -600000, 30, -40};

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      rdy[k] = 1'b0;
      armed[k] = 1'b0;
      done_at[k] = -1;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero(0, "reset");
    check_outputs_zero(1, "reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Basic 4x4 run with hand-computed windows.
    fill_basic();
    run(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_basic_d0[%0d]", i), e_d[0][0][i], lit_d[i]);
      chk($sformatf("basic_d0[%0d]", i), g_d0[0][i], lit_d[i]);
      chk($sformatf("basic_bram[%0d]", i), g_b[0][i], lit_b[i]);
      chk($sformatf("basic_wraddr[%0d]", i), g_wa[0][i], lit_wa[i]);
    end
    chk("basic_done_T11", done_at[0] - t0[0], 10);

    // Signed compare, saturation and distinct per-channel patterns.
    for (int a = 0; a < 8; a++) begin
      up[0][0][a] = sv_up[a];
      lo[0][0][a] = sv_lo[a];
      up[0][1][a] = 100 * a - 350;
      lo[0][1][a] = -40 * a;
      up[0][2][a] = (a % 3) * 7000 - 9000;
      lo[0][2][a] = 1000 - a * a * 500;
    end
    run(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_signed_d0[%0d]", i), e_d[0][0][i], lit_s[i]);
      chk($sformatf("signed_d0[%0d]", i), g_d0[0][i], lit_s[i]);
    end
    chk("model_c1_w0", e_d[0][1][0], 0);
    chk("model_c2_w0", e_d[0][2][0], 1000);

    // Start pulse while busy must be ignored.
    fill_basic();
    run(0, 1'b1);
    chk("busy_done_T11", done_at[0] - t0[0], 10);

    // Reset mid-READ aborts at once; no done pulse follows.
    start(0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst[0] = 1'b1;
    #1 check_outputs_zero(0, "midreset");
    armed[0] = 1'b0;
    e_h[0] = e_n[0];
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("midreset_no_done", done_at[0], -1);
    run(0, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("after_reset_d0[%0d]", i), g_d0[0][i], lit_d[i]);

    // Default geometry with random data over the full signed input range.
    for (int a = 0; a < 512; a++)
      for (int ch = 0; ch < 3; ch++) begin
        up[1][ch][a] = int'($urandom_range(0, 2097151)) - 1048576;
        lo[1][ch][a] = int'($urandom_range(0, 2097151)) - 1048576;
      end
    run(1, 1'b0);
    chk("big_writes", e_h[1], 256);
    chk("big_max_wraddr", max_wa[1], 63);
    chk("big_done_T515", done_at[1] - t0[1], 514);
    for (int r = 0; r < 5; r++) chk($sformatf("big_bram_row%0d", r), g_b[1][r * 16], r % 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pool2x2_stage.md
# pool2x2_stage

2x2 stride-2 max-pooling stage that sits directly downstream of the first-layer intermediate BRAM bank (`mid_bram`) and upstream of the pooled-feature BRAM bank. On a start pulse it streams pairs of vertically adjacent conv results for three channels out of the intermediate bank, reduces each 2x2 window to its signed maximum, saturates from the conv result width to the pipeline data width, and writes the pooled pixels round-robin across four output BRAMs. It raises a one-cycle completion pulse when the whole feature map is pooled.

## Interface

Parameters:
- `BD`, 18: output data width (signed, two's complement).
- `IW`, 21: input data width (signed conv result).
- `IMG_W`, 32: input feature-map width in pixels; even, ≥ 2.
- `IMG_H`, 32: input feature-map height in rows; even, ≥ 2.
- `AW`, 11: read and write address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `ready_in` in 1: start pulse; intermediate bank is fully written.
- `q0_c0`, `q0_c1`, `q0_c2` in IW each: upper-row pixel for channels 0–2, valid one cycle after `mpen`.
- `q1_c0`, `q1_c1`, `q1_c2` in IW each: lower-row pixel for channels 0–2, valid one cycle after `mpen`.
- `mpen` out 1: read enable to intermediate bank.
- `rdaddr` out AW: read address.
- `wren` out 1: write enable for the pooled pixel.
- `wraddr` out AW: write address within the selected output BRAM.
- `d_c0`, `d_c1`, `d_c2` out BD each: pooled, saturated pixels.
- `bram_num` out 2: selects the output BRAM (0–3).
- `next_st` out 1: one-cycle done pulse.

## Operation

- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: waits for `ready_in`=1, then clears row counter r and column counter c and goes to READ.
- READ: each cycle, assert `mpen` with `rdaddr` = r·IMG_W + c, then increment c. When c = IMG_W−1, wrap c to 0 and increment r. After the read of r = IMG_H/2−1, c = IMG_W−1, go to DRAIN.
- DRAIN: 2 cycles with no reads so the last write can retire, then go to DONE.
- DONE: assert `next_st` for 1 cycle, then return to IDLE.
- `ready_in` outside IDLE is ignored.
- Read data, with c being the column of the read issued one cycle earlier:
  - Even c: register the vertical max vmax = max(q0, q1) per channel, signed compare.
  - Odd c: compute m = max(vmax_held, max(q0, q1)) per channel.
- Saturation: if m > 2^(BD−1)−1, output 2^(BD−1)−1. If m < −2^(BD−1), output −2^(BD−1). Otherwise output m[BD−1:0].
- Write: for pooled output row r and column c>>1, set `bram_num` = r[1:0] and `wraddr` = (r>>2)·(IMG_W/2) + (c>>1).
- `bram_num`, `wraddr` and `d_c*` are registered together with `wren`.
- No ReLU is applied; signed values pass through.

## Timing

- Reset values: all outputs are 0, the FSM is in IDLE, and the counters and vmax registers are 0.
- `RESET` mid-operation aborts immediately. No further `mpen` or `wren` is issued and no `next_st` pulse occurs. A fresh `ready_in` is required.
- `ready_in` sampled at cycle T gives the first `mpen` at T+1.
- Reads are back-to-back, one per cycle. READ lasts exactly (IMG_H/2)·IMG_W cycles.
- BRAM read latency is 1 cycle: `mpen` at cycle t gives q valid at t+1.
- A read of odd column issued at t gives `wren`=1 at t+2 with the corresponding data.
- `wren` pulses every second cycle during streaming, (IMG_H/2)·(IMG_W/2) pulses in total.
- `next_st` rises 1 cycle after the final `wren`.
- For a start at T, the total is `next_st` at T + (IMG_H/2)·IMG_W + 3.
- `mpen` is low in IDLE, DRAIN and DONE.
- Row wrap-around resets c-parity tracking; windows never span rows.

## Test plan

- **Basic 4x4 run.** IMG_W=4, IMG_H=4, BD=18, IW=21. Upper row = addr·2, lower row = addr·2+1, all channels. Pulse `ready_in`. Expect exactly 4 `wren` pulses:
  - `d_c0` values 3, 7, 11, 15.
  - (`bram_num`, `wraddr`) = (0,0), (0,1), (1,0), (1,1).
  - `next_st` at T+11.
- **Signed compare and saturation.** Window {−5, −3, −9, −7} → −3. Window containing 500000 → 131071. Window of all −600000 → −131072.
- **Channel independence.** Different patterns on c0, c1 and c2 → each `d_c*` equals its own window max with no cross-channel leakage.
- **Start while busy.** Pulse `ready_in` again mid-READ → ignored. Output count and `next_st` timing are unchanged.
- **Mid-run reset.** Assert `RESET` during READ → all outputs go to 0 in the same cycle, with no `next_st`. A later `ready_in` → a full correct run.
- **Default parameters.** IMG_W=32, IMG_H=32, random data against a reference model:
  - 256 writes total.
  - `bram_num` cycles 0..3 per output row.
  - Maximum `wraddr` = 63.
  - `next_st` at T+515.
